// File: rtl/turbo_encoder_rsc.sv
// Rate-1/3 turbo encoder: two (7,5) RSC encoders, the second fed through a ROWS x COLS block
// interleaver, two trellis-termination beats per frame. Define PUNCT_EN for rate-1/2 output.
module turbo_encoder_rsc #(
    parameter  int ROWS      = 4,
    parameter  int COLS      = 4,
    localparam int FRAME_LEN = ROWS * COLS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [FRAME_LEN-1:0] i_data,
    output logic [3:0]           o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_done
);
    localparam int CW = $clog2(FRAME_LEN);
    localparam int RB = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, ENC, TAIL} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [FRAME_LEN-1:0] frm;
    logic                 s1a, s2a, s1b, s2b;

    logic [RB-1:0]        row;
    logic [CW-RB-1:0]     col;
    logic [CW-1:0]        pidx;
    logic                 ua, ub, aa, ab, pa, pb;
    logic [3:0]           enc_word, tail_word;

    // pi(k) = (k % ROWS)*COLS + k/ROWS reduces to swapping the bit fields of k.
    assign row  = cnt[RB-1:0];
    assign col  = cnt[CW-1:RB];
    assign pidx = {row, col};

    always_comb begin
        ua = frm[cnt];
        ub = frm[pidx];
        if (state == TAIL) begin
            // Termination input cancels the feedback so the register flushes to 00.
            ua = s1a ^ s2a;
            ub = s1b ^ s2b;
        end
        aa = ua ^ s1a ^ s2a;
        ab = ub ^ s1b ^ s2b;
        pa = aa ^ s2a;
        pb = ab ^ s2b;
    end

`ifdef PUNCT_EN
    assign enc_word  = {2'b00, (cnt[0] ? pb : pa), ua};
`else
    assign enc_word  = {1'b0, pb, pa, ua};
`endif
    assign tail_word = {ub, pb, pa, ua};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            frm     <= '0;
            s1a     <= 1'b0;
            s2a     <= 1'b0;
            s1b     <= 1'b0;
            s2b     <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_valid <= 1'b0;
                    o_done  <= 1'b0;
                    if (i_start) begin
                        frm    <= i_data;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= ENC;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ENC: begin
                    o_valid <= 1'b1;
                    o_data  <= enc_word;
                    s1a     <= aa;
                    s2a     <= s1a;
                    s1b     <= ab;
                    s2b     <= s1b;
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(FRAME_LEN - 1)) state <= TAIL;
                end
                TAIL: begin
                    o_valid <= 1'b1;
                    o_data  <= tail_word;
                    s1a     <= aa;
                    s2a     <= s1a;
                    s1b     <= ab;
                    s2b     <= s1b;
                    if (cnt[0]) begin
                        o_done <= 1'b1;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_turbo_encoder_rsc.sv
// Randomised bench for turbo_encoder_rsc against a sequence-level reference model.
module tb_turbo_encoder_rsc;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int FL = R * C;
    localparam int NB = FL + 2;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [FL-1:0] i_data = '0;
    logic [3:0]    o_data;
    logic          o_valid, o_busy, o_done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] expv [NB];

    turbo_encoder_rsc #(.ROWS(R), .COLS(C)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_data(i_data),
        .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Recursive code as a sequence: a[k] = u[k]^a[k-1]^a[k-2], p[k] = a[k]^a[k-2].
    task automatic rsc_seq(input logic [FL-1:0] u, output logic [NB-1:0] p, output logic [1:0] ut);
        int a [NB+2];
        a[0] = 0;
        a[1] = 0;
        p  = '0;
        ut = '0;
        for (int k = 0; k < FL; k++) begin
            a[k+2] = int'(u[k]) ^ a[k+1] ^ a[k];
            p[k]   = 1'(a[k+2] ^ a[k]);
        end
        for (int t = 0; t < 2; t++) begin
            ut[t]     = 1'(a[FL+t+1] ^ a[FL+t]);
            a[FL+t+2] = 0;
            p[FL+t]   = 1'(a[FL+t]);
        end
    endtask

    task automatic build_exp(input logic [FL-1:0] d);
        logic [FL-1:0] d2;
        logic [NB-1:0] p1, p2;
        logic [1:0]    t1, t2;
        for (int k = 0; k < FL; k++) d2[k] = d[(k % R) * C + k / R];
        rsc_seq(d,  p1, t1);
        rsc_seq(d2, p2, t2);
        for (int k = 0; k < FL; k++) begin
`ifdef PUNCT_EN
            expv[k] = {2'b00, ((k % 2 == 0) ? p1[k] : p2[k]), d[k]};
`else
            expv[k] = {1'b0, p2[k], p1[k], d[k]};
`endif
        end
        for (int t = 0; t < 2; t++) expv[FL+t] = {t2[t], p2[FL+t], p1[FL+t], t1[t]};
    endtask

    task automatic start_frame(input logic [FL-1:0] d, input string tag);
        @(negedge i_clk);
        i_start = 1'b1;
        i_data  = d;
        build_exp(d);
        @(negedge i_clk);
        i_start = 1'b0;
        chk({tag, "_busy_on"}, o_busy, 1);
        chk({tag, "_lat_valid0"}, o_valid, 0);
    endtask

    // Checks beats [0,nb); optionally swaps i_data after beat 5 to prove it is ignored.
    task automatic check_beats(input string tag, input int nb, input bit swap, input logic [FL-1:0] nd);
        for (int b = 0; b < nb; b++) begin
            @(negedge i_clk);
            chk($sformatf("%s_valid_b%0d", tag, b), o_valid, 1);
            chk($sformatf("%s_data_b%0d", tag, b), o_data, expv[b]);
            chk($sformatf("%s_done_b%0d", tag, b), o_done, (b == NB - 1) ? 1 : 0);
            chk($sformatf("%s_busy_b%0d", tag, b), o_busy, 1);
            if (swap && b == 5) i_data = nd;
        end
    endtask

    task automatic end_idle(input string tag);
        @(negedge i_clk);
        chk({tag, "_idle_valid"}, o_valid, 0);
        chk({tag, "_idle_busy"}, o_busy, 0);
        chk({tag, "_idle_done"}, o_done, 0);
        chk({tag, "_idle_hold"}, o_data, expv[NB-1]);
    endtask

    task automatic run_frame(input logic [FL-1:0] d, input string tag);
        start_frame(d, tag);
        check_beats(tag, NB, 1'b0, '0);
        end_idle(tag);
    endtask

    initial begin
        logic [FL-1:0] fa, fb;
        repeat (2) @(negedge i_clk);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        i_rst_n = 1'b1;

        run_frame(16'h0000, "t1_zero");
        run_frame(16'h0001, "t2_imp0");
        run_frame(16'h0002, "t3_imp1");
        run_frame(16'hFFFF, "ones");
        for (int i = 0; i < 6; i++) run_frame(FL'($urandom), $sformatf("rnd%0d", i));

        // Start held high: mid-frame data change ignored, second frame accepted right after done.
        fa = FL'($urandom);
        fb = FL'($urandom);
        @(negedge i_clk);
        i_start = 1'b1;
        i_data  = fa;
        build_exp(fa);
        @(negedge i_clk);
        chk("t4_busy_on", o_busy, 1);
        check_beats("t4a", NB, 1'b1, fb);
        @(negedge i_clk);
        i_start = 1'b0;
        chk("t4_gap_valid", o_valid, 0);
        chk("t4_gap_busy", o_busy, 1);
        build_exp(fb);
        check_beats("t4b", NB, 1'b0, '0);
        end_idle("t4b");

        // Reset mid-frame aborts immediately; following frame encodes from a clean state.
        start_frame(FL'($urandom), "t5a");
        check_beats("t5a", 8, 1'b0, '0);
        i_rst_n = 1'b0;
        #1;
        chk("t5_rst_data", o_data, 0);
        chk("t5_rst_valid", o_valid, 0);
        chk("t5_rst_busy", o_busy, 0);
        chk("t5_rst_done", o_done, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        run_frame(16'hF2CF, "t5b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
